// File: rtl/mbssoc_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among CORE_NUM cores.
// Posedge request/grant/ack with bounded lock sequences for atomic RMW.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req, we, lock          per-core request, write enable, keep-bus flag
//   addr_flat, wdata_flat  per-core address / write data, packed by core
//   cpu_pause, ack         per-core stall and one-cycle completion pulse
//   rdata                  read data broadcast, valid with ack on reads
//   ram_re, ram_we         RAM strobes
//   ram_addr, ram_wdata    RAM address / write data
//   ram_rdata              RAM read data, one cycle after ram_re
//   grant_id               granted core index this cycle, 0 when idle
module mbssoc_ram_arbiter #(
    parameter int CORE_NUM   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CORE_NUM-1:0]            req,
    input  logic [CORE_NUM-1:0]            we,
    input  logic [CORE_NUM-1:0]            lock,
    input  logic [CORE_NUM*ADDR_WIDTH-1:0] addr_flat,
    input  logic [CORE_NUM*DATA_WIDTH-1:0] wdata_flat,
    output logic [CORE_NUM-1:0]            cpu_pause,
    output logic [CORE_NUM-1:0]            ack,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           ram_re,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]          ram_wdata,
    input  logic [DATA_WIDTH-1:0]          ram_rdata,
    output logic [$clog2(CORE_NUM)-1:0]    grant_id
);

    localparam int IW = $clog2(CORE_NUM);
    localparam int CW = $clog2(MAX_LOCK + 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]          r_state;
    logic [IW-1:0]       r_own;
    logic [CW-1:0]       r_lock_cnt;
    logic [IW-1:0]       r_ptr;
    logic                r_ack_pend;
    logic                r_ack_rd;
    logic [IW-1:0]       r_ack_id;

    logic                w_gnt_vld;
    logic [IW-1:0]       w_gnt_id;
    logic [CORE_NUM-1:0] w_gnt_vec;
    logic                w_own_hold;
    logic [CW-1:0]       w_cnt_next;
    logic                w_keep;
    logic [IW-1:0]       w_ptr_gnt;
    logic [IW-1:0]       w_ptr_own;

    assign w_own_hold = (r_state == S_LOCKED) && req[r_own];

    // Lowest rotation offset from r_ptr wins; scan downward so it
    // overwrites the others.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        if (!rst) begin
            if (w_own_hold) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = r_own;
            end else begin
                for (int k = CORE_NUM - 1; k >= 0; k--) begin
                    if (req[(int'(r_ptr) + k) % CORE_NUM]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = IW'((int'(r_ptr) + k) % CORE_NUM);
                    end
                end
            end
        end
    end

    always_comb begin
        w_gnt_vec = '0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_gnt_vld) begin
            w_gnt_vec[w_gnt_id] = 1'b1;
            ram_we    = we[w_gnt_id];
            ram_re    = ~we[w_gnt_id];
            ram_addr  = addr_flat[int'(w_gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wdata = wdata_flat[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A new owner (after an early release) starts its own count at zero.
    assign w_cnt_next = (w_own_hold ? r_lock_cnt : CW'(0)) + CW'(1);
    assign w_keep     = lock[w_gnt_id] && (w_cnt_next < CW'(MAX_LOCK));

    assign w_ptr_gnt = (int'(w_gnt_id) == CORE_NUM - 1) ? '0 : w_gnt_id + IW'(1);
    assign w_ptr_own = (int'(r_own) == CORE_NUM - 1) ? '0 : r_own + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_own      <= '0;
            r_lock_cnt <= '0;
            r_ptr      <= '0;
            r_ack_pend <= 1'b0;
            r_ack_rd   <= 1'b0;
            r_ack_id   <= '0;
        end else begin
            r_ack_pend <= w_gnt_vld;
            r_ack_rd   <= w_gnt_vld & ~we[w_gnt_id];
            r_ack_id   <= w_gnt_id;
            if (w_gnt_vld) begin
                if (w_keep) begin
                    r_state    <= S_LOCKED;
                    r_own      <= w_gnt_id;
                    r_lock_cnt <= w_cnt_next;
                end else begin
                    r_state    <= S_IDLE;
                    r_lock_cnt <= '0;
                    r_ptr      <= w_ptr_gnt;
                end
            end else if (r_state == S_LOCKED) begin
                // Owner dropped req and nobody else asked: release.
                r_state    <= S_IDLE;
                r_lock_cnt <= '0;
                r_ptr      <= w_ptr_own;
            end
        end
    end

    always_comb begin
        ack = '0;
        if (r_ack_pend && !rst) begin
            ack[r_ack_id] = 1'b1;
        end
    end

    assign rdata     = (r_ack_pend && r_ack_rd && !rst) ? ram_rdata : '0;
    assign cpu_pause = req & ~w_gnt_vec;
    assign grant_id  = w_gnt_id;

endmodule

// File: doc/mbssoc_ram_arbiter.md
# mbssoc_ram_arbiter

Round-robin arbiter that shares the single-port SoC RAM between `CORE_NUM` MBScore cores. It supersedes the fixed-priority, negedge bus control with a posedge request/grant/ack scheme. It adds fair rotation, bounded atomic lock sequences for read-modify-write, and a registered read-return path. It sits between the cores' memory ports and the RAM, and drives each core's `cpu_pause`.

## Interface
- `CORE_NUM`, 2, number of requesting cores (≥2)
- `ADDR_WIDTH`, 32, RAM address width
- `DATA_WIDTH`, 32, RAM data width
- `MAX_LOCK`, 4, max consecutive grants one locked owner may hold (≥1)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous active-high reset; one clock, reset is synchronous and active-high
- `req`  in  CORE_NUM  per-core access request, level, held until `ack`
- `we`  in  CORE_NUM  per-core write enable (1 = write, 0 = read), valid with `req`
- `lock`  in  CORE_NUM  per-core "keep bus after this access"
- `addr_flat`  in  CORE_NUM*ADDR_WIDTH  core i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `wdata_flat`  in  CORE_NUM*DATA_WIDTH  core i write data, same packing
- `cpu_pause`  out  CORE_NUM  stall to core i
- `ack`  out  CORE_NUM  one-cycle completion pulse to core i
- `rdata`  out  DATA_WIDTH  read data broadcast to all cores, valid with `ack`
- `ram_re`, `ram_we`  out  1  RAM strobes
- `ram_addr`  out  ADDR_WIDTH  RAM address
- `ram_wdata`  out  DATA_WIDTH  RAM write data
- `ram_rdata`  in  DATA_WIDTH  RAM read data, registered in RAM, valid one cycle after `ram_re`
- `grant_id`  out  $clog2(CORE_NUM)  index of core granted this cycle (debug), 0 when idle

## Operation
- State: `IDLE` (no owner) and `LOCKED` (owner `own`, counter `lock_cnt`). Also a priority pointer `ptr`, a registered `ack_pend` and `ack_id`.
- Grant is combinational, decided each cycle:
  - In `LOCKED` with `req[own]`=1, grant `own`.
  - Otherwise, grant the first requesting core found scanning `ptr, ptr+1, …` modulo CORE_NUM.
  - If no core requests, there is no grant.
- Outputs for the granted core g:
  - `ram_re = ~we[g]`, `ram_we = we[g]`.
  - `ram_addr`/`ram_wdata` are taken from slice g.
  - With no grant: strobes are 0, and addr/wdata are 0.
- `cpu_pause[i] = req[i] & ~grant[i]`. A granted core is not paused in its grant cycle. It is paused from the next cycle if it holds `req` while awaiting `ack`.
- Each grant is exactly one RAM access. `ack[g]` pulses the following cycle. `rdata` equals `ram_rdata` during that cycle for reads and is don't-care for writes.
- The core must drop or re-present `req` in its `ack` cycle. A core with `req`=1 in its own `ack` cycle is treated as a new request.
- State update at each edge with grant g:
  - If `lock[g]`=1 and `lock_cnt+1 < MAX_LOCK`: go to `LOCKED`, set `own=g`, increment `lock_cnt`.
  - Otherwise: go to `IDLE`, set `lock_cnt=0`, set `ptr=(g+1) mod CORE_NUM`.
- In `LOCKED`, if the owner drops `req`, the lock releases immediately. The same cycle arbitrates round-robin among the others, and `ptr` moves past `own`.
- Width: `lock_cnt` is $clog2(MAX_LOCK+1) bits. `ptr` wraps from CORE_NUM-1 to 0.

## Timing
- Reset (`rst`=1 at an edge):
  - State goes to `IDLE`; `ptr`, `lock_cnt`, `own`, `ack_pend` and `ack_id` go to 0.
  - While `rst` is high: `ack`=0, `ram_re`=`ram_we`=0, `ram_addr`/`ram_wdata`=0 and `grant_id`=0.
  - While `rst` is high, `cpu_pause=req` (no grants).
- Latency: a request in the cycle the core wins arbitration gets `ack` exactly 1 cycle later. Worst-case wait for a core without lock is (CORE_NUM-1)·MAX_LOCK grant cycles.
- Throughput: one RAM access per cycle, back-to-back across cores, no bubbles.
- Reset during an outstanding access: the pending `ack` is discarded (not emitted). A lock in progress is abandoned.
- Simultaneous requests from all cores in `IDLE`: `ptr` wins.
- `lock` on a core without a grant has no effect.
- `MAX_LOCK`=1: `lock` never holds the bus.

## Test plan
- Reset hold: assert `rst` for 3 cycles with `req`=2'b11. Required: `cpu_pause`=2'b11, `ram_re`=`ram_we`=0 and `ack`=0 throughout. In the first cycle after reset, core 0 is granted.
- Round-robin fairness: hold `req`=2'b11 (reads, addr0=0x10, addr1=0x20) for 6 cycles. Required: `ram_addr` = 0x10, 0x20, 0x10, 0x20, … with no idle cycle, and `ack` = 01, 10, 01, … each lagging its grant by 1 cycle.
- Write then read: core 1 writes 0xDEADBEEF to 0x40, then reads 0x40. Required: `ram_we`=1 on cycle 0, `ack[1]` on cycle 1, `ram_re` on cycle 1, and `rdata`=0xDEADBEEF with `ack[1]` on cycle 2.
- Lock limit (MAX_LOCK=4): core 0 requests with `lock`=1 continuously while core 1 requests. Required: core 0 is granted 4 consecutive cycles, then core 1 once; `cpu_pause[1]`=1 during core 0's 4 cycles.
- Early release: core 0 locks and drops `req` after 2 grants. Required: core 1 is granted in the next cycle and `ptr` becomes 0.
- Reset mid-access: assert `rst` in the cycle after a grant to core 1. Required: no `ack[1]` pulse and state `IDLE`.
